// File: rtl/audio_pkg.sv
// Shared types and widths for the audio PWM DAC block.
package audio_pkg;
  localparam int PWM_BITS = 8;
  localparam int SAMPLE_W = 8;
  localparam int VOL_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } play_state_e;
endpackage

// File: rtl/audio_pwm_dac_if.sv
// Sample stream handshake from sound_generator into the PWM DAC.
interface audio_pwm_dac_if;
  import audio_pkg::*;

  logic [SAMPLE_W-1:0] sample_i;
  logic                sample_valid_i;
  logic                sample_ready_o;

  modport master (output sample_i, output sample_valid_i, input sample_ready_o);
  modport slave  (input sample_i, input sample_valid_i, output sample_ready_o);
endinterface

// File: rtl/audio_pwm_dac_sample_fifo.sv
// Small synchronous sample FIFO with registered level/full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // Pointer and occupancy update; push and pop together leave the level unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  // Control state; contents are simply abandoned on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Sample storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/audio_pwm_dac.sv
// Audio PWM DAC: buffers 8-bit samples, applies a 3-bit gain and renders each
// sample as one 256-clock PWM period. A playback FSM primes the FIFO, holds
// the last level on underrun and falls back to silent IDLE after a timeout.
// Optional macro AUDIO_DAC_ERROR_FEEDBACK_EN adds a residual accumulator that
// feeds the truncated product bits back into the duty.
module audio_pwm_dac
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int PRIME_LEVEL  = 2,
  parameter int HOLD_PERIODS = 16,
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1),
  localparam int HOLD_W = $clog2(HOLD_PERIODS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  audio_pwm_dac_if.slave       smp,
  input  logic [VOL_W-1:0]     volume_i,
  input  logic                 mute_i,
  output logic                 pwm_o,
  output logic                 period_strobe_o,
  output logic                 underrun_o,
  output logic [LVL_W-1:0]     fifo_level_o
);
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  play_state_e         state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                pwm_q, pwm_d;

  logic [SAMPLE_W-1:0] head;
  logic [LVL_W-1:0]    level;
  logic                full, empty;
  logic                push, pop, underrun;
  logic                boundary;
  logic [VOL_W:0]      vol_gain;
  logic [10:0]         prod;
  logic [PWM_BITS-1:0] scaled_duty;

  function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] base,
                                                  input logic inc);
    logic [PWM_BITS:0] sum;
    sum = {1'b0, base} + {{PWM_BITS{1'b0}}, inc};
    return sum[PWM_BITS] ? {PWM_BITS{1'b1}} : sum[PWM_BITS-1:0];
  endfunction

  assign smp.sample_ready_o = !full && !rst;
  assign push               = smp.sample_valid_i && smp.sample_ready_o;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (smp.sample_i),
    .pop   (pop),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign boundary = (cnt_q == {PWM_BITS{1'b1}});
  assign vol_gain = {1'b0, volume_i} + (VOL_W + 1)'(1);
  assign prod     = {3'b000, head} * {7'b0000000, vol_gain};

`ifdef AUDIO_DAC_ERROR_FEEDBACK_EN
  logic [2:0] acc_q, acc_d;
  logic [3:0] acc_sum;

  assign acc_sum     = {1'b0, acc_q} + {1'b0, prod[2:0]};
  assign scaled_duty = sat_inc(prod[10:3], acc_sum[3]);

  // Residual accumulator: absorbs dropped bits on each pop, cleared entering IDLE.
  always_comb begin
    acc_d = acc_q;
    if (pop) acc_d = acc_sum[2:0];
    if (state_d == IDLE && state_q != IDLE) acc_d = '0;
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`else
  assign scaled_duty = sat_inc(PWM_BITS'(prod >> 3), 1'b0);
`endif

  // Playback FSM, duty load and PWM compare; all decisions happen at period boundaries.
  always_comb begin
    cnt_d    = cnt_q + PWM_BITS'(1);
    duty_d   = duty_q;
    state_d  = state_q;
    hold_d   = hold_q;
    pop      = 1'b0;
    underrun = 1'b0;
    if (boundary) begin
      unique case (state_q)
        IDLE: begin
          duty_d = '0;
          if (level >= LVL_W'(PRIME_LEVEL)) begin
            pop     = 1'b1;
            duty_d  = scaled_duty;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (!empty) begin
            pop    = 1'b1;
            duty_d = scaled_duty;
          end else begin
            underrun = 1'b1;
            hold_d   = '0;
            state_d  = HOLD;
          end
        end
        HOLD: begin
          if (!empty) begin
            pop     = 1'b1;
            duty_d  = scaled_duty;
            state_d = PLAY;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
            if (hold_d == HOLD_W'(HOLD_PERIODS)) begin
              state_d = IDLE;
              duty_d  = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
        end
      endcase
    end
    pwm_d = (state_q != IDLE) && !mute_i && (cnt_q < duty_q);
  end

  // State, counter, duty and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      duty_q  <= '0;
      state_q <= IDLE;
      hold_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_o           = pwm_q;
  assign period_strobe_o = boundary;
  assign underrun_o      = underrun;
  assign fifo_level_o    = level;
endmodule
